// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RV32I funct3 codes,
// access-size encoding, FSM state encoding and the fault decode.
package lsu_pkg;

  // RV32I load/store width/sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size is carried in funct3[1:0]; funct3[2] selects zero extension
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_WRITE,
    ST_RESP
  } lsu_state_t;

  // Illegal width code for the direction, or address not aligned to the size
  function automatic logic lsu_is_fault(input logic write, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic bad_code;
    logic misaligned;
    if (write)
      bad_code = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
    else
      bad_code = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    misaligned = ((f3[1:0] == SZ_H) && off[0]) ||
                 ((f3[1:0] == SZ_W) && (off != 2'b00));
    return bad_code || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extraction with sign/zero extension, and
// sub-word merge of store data into a read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  input  logic [15:0] store_lane,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        sext;

  // Select the addressed lane and extend it for loads
  always_comb begin
    sext = ~funct3[2];
    case (byte_off)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    sel_half = byte_off[1] ? word[31:16] : word[15:0];
    case (funct3[1:0])
      SZ_B:    load_data = {{24{sext & sel_byte[7]}}, sel_byte};
      SZ_H:    load_data = {{16{sext & sel_half[15]}}, sel_half};
      default: load_data = word;
    endcase
  end

  // Insert the low store bits into the addressed lane of the read word
  always_comb begin
    merge_data = word;
    if (funct3[1:0] == SZ_H) begin
      if (byte_off[1]) merge_data[31:16] = store_lane;
      else             merge_data[15:0]  = store_lane;
    end else if (funct3[1:0] == SZ_B) begin
      case (byte_off)
        2'd0:    merge_data[7:0]   = store_lane[7:0];
        2'd1:    merge_data[15:8]  = store_lane[7:0];
        2'd2:    merge_data[23:16] = store_lane[7:0];
        default: merge_data[31:24] = store_lane[7:0];
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with read-modify-write for sub-word
// stores against a word-wide memory with combinational read.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  state, state_nx;
  logic        req_write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        fault_q;
  logic [31:0] store_buf;
  logic [31:0] load_word;
  logic [31:0] merged_word;
  logic        req_fault;
  logic        accept;

  assign req_fault = lsu_is_fault(req_write, funct3, addr[1:0]);
  assign accept    = req_valid && (state == ST_IDLE);

  lsu_align u_align (
    .word       (mem_read_data),
    .byte_off   (addr_q[1:0]),
    .funct3     (funct3_q),
    .store_lane (wdata_q[15:0]),
    .load_data  (load_word),
    .merge_data (merged_word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Capture the request on acceptance; held until the next acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      req_write_q <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      fault_q     <= 1'b0;
    end else if (accept) begin
      req_write_q <= req_write;
      funct3_q    <= funct3;
      addr_q      <= addr;
      wdata_q     <= wdata;
      fault_q     <= req_fault;
    end
  end

  // Load result and RMW store buffer, written only in their data states
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata     <= '0;
      store_buf <= '0;
    end else begin
      if (state == ST_LOAD)   rdata     <= load_word;
      if (state == ST_RMW_RD) store_buf <= merged_word;
    end
  end

  // Next-state routing and state-decoded outputs
  always_comb begin
    state_nx       = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    fault          = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = {2'b00, addr_q[31:2]};
    mem_write_data = (req_write_q && (funct3_q == F3_W)) ? wdata_q : store_buf;
    case (state)
      ST_IDLE: begin
        req_ready   = 1'b1;
        mem_address = '0;
        if (req_valid) begin
          if (req_fault)          state_nx = ST_RESP;
          else if (!req_write)    state_nx = ST_LOAD;
          else if (funct3 == F3_W) state_nx = ST_WRITE;
          else                    state_nx = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        mem_read = 1'b1;
        state_nx = ST_RESP;
      end
      ST_RMW_RD: begin
        mem_read = 1'b1;
        state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        mem_write = 1'b1;
        state_nx  = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        fault      = fault_q;
        state_nx   = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 16-word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        fault;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:15];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .funct3         (funct3),
    .addr           (addr),
    .wdata          (wdata),
    .resp_valid     (resp_valid),
    .rdata          (rdata),
    .fault          (fault),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  assign mem_read_data = mem[mem_address[3:0]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[3:0]] <= mem_write_data;
  end

  // Issue one request, accept at edge 0, scramble inputs, and record what
  // happens in cycles 1..8 (cycle numbers relative to the accepting edge).
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic ready0, output int resp_cyc,
                        output logic flt, output int rd_cnt, output int wr_cyc,
                        output logic [31:0] wr_idx, output logic [31:0] wr_dat);
    resp_cyc = 0; flt = 1'b0; rd_cnt = 0; wr_cyc = 0; wr_idx = '0; wr_dat = '0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; funct3 = f3; addr = a; wdata = d;
    ready0 = req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~wr; funct3 = 3'b111;
    addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_read) rd_cnt++;
      if (mem_write) begin
        wr_cyc = c; wr_idx = mem_address; wr_dat = mem_write_data;
      end
      if (resp_valid) begin
        resp_cyc = c; flt = fault;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b111;
    addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
    n_tests++;
    if ({resp_valid, fault, mem_read, mem_write} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl got %b want 0000", {resp_valid, fault, mem_read, mem_write});
    end
    n_tests++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 00000000", rdata); end
    n_tests++;
    if (mem_address !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 00000000", mem_address); end
    @(negedge clk);
    n_tests++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_priority resp_valid got %b want 0", resp_valid); end
  endtask

  task automatic test_loads;
    logic r0, flt; int rc, rd, wc; logic [31:0] wi, wd;
    mem[4] = 32'h8000_00F1;
    do_req(1'b0, 3'b000, 32'h10, 32'h0, r0, rc, flt, rd, wc, wi, wd);
    n_tests++;
    if (r0 !== 1'b1 || rc !== 2 || flt !== 1'b0 || rd !== 1 || wc !== 0) begin
      n_fail++; $display("FAIL lb_timing ready=%b resp=%0d fault=%b reads=%0d wr=%0d want 1 2 0 1 0", r0, rc, flt, rd, wc);
    end
    n_tests++;
    if (rdata !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL lb_data got %h want FFFFFFF1", rdata); end
    do_req(1'b0, 3'b100, 32'h10, 32'h0, r0, rc, flt, rd, wc, wi, wd);
    n_tests++;
    if (rc !== 2 || rdata !== 32'h0000_00F1) begin n_fail++; $display("FAIL lbu got %h resp=%0d want 000000F1 2", rdata, rc); end
    do_req(1'b0, 3'b001, 32'h12, 32'h0, r0, rc, flt, rd, wc, wi, wd);
    n_tests++;
    if (rc !== 2 || rdata !== 32'hFFFF_8000) begin n_fail++; $display("FAIL lh got %h resp=%0d want FFFF8000 2", rdata, rc); end
    do_req(1'b0, 3'b101, 32'h12, 32'h0, r0, rc, flt, rd, wc, wi, wd);
    n_tests++;
    if (rdata !== 32'h0000_8000) begin n_fail++; $display("FAIL lhu got %h want 00008000", rdata); end
    do_req(1'b0, 3'b000, 32'h13, 32'h0, r0, rc, flt, rd, wc, wi, wd);
    n_tests++;
    if (rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_lane3 got %h want FFFFFF80", rdata); end
  endtask

  task automatic test_sub_store;
    logic r0, flt; int rc, rd, wc; logic [31:0] wi, wd;
    mem[2] = 32'h1122_3344;
    do_req(1'b1, 3'b000, 32'h09, 32'h1234_56AB, r0, rc, flt, rd, wc, wi, wd);
    n_tests++;
    if (wc !== 2 || wi !== 32'd2 || wd !== 32'h1122_AB44) begin
      n_fail++; $display("FAIL sb_write cyc=%0d idx=%h data=%h want 2 00000002 1122AB44", wc, wi, wd);
    end
    n_tests++;
    if (rc !== 3 || flt !== 1'b0 || rd !== 1) begin n_fail++; $display("FAIL sb_resp resp=%0d fault=%b reads=%0d want 3 0 1", rc, flt, rd); end
    n_tests++;
    if (rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL sb_rdata_hold got %h want FFFFFF80", rdata); end
    do_req(1'b1, 3'b001, 32'h0A, 32'hFFFF_5566, r0, rc, flt, rd, wc, wi, wd);
    @(negedge clk);
    n_tests++;
    if (rc !== 3 || mem[2] !== 32'h5566_AB44) begin n_fail++; $display("FAIL sh_merge mem=%h resp=%0d want 5566AB44 3", mem[2], rc); end
  endtask

  task automatic test_word;
    logic r0, flt; int rc, rd, wc; logic [31:0] wi, wd;
    mem[3] = 32'h0;
    do_req(1'b1, 3'b010, 32'h0C, 32'hDEAD_BEEF, r0, rc, flt, rd, wc, wi, wd);
    n_tests++;
    if (wc !== 1 || wi !== 32'd3 || wd !== 32'hDEAD_BEEF || rc !== 2 || rd !== 0) begin
      n_fail++; $display("FAIL sw wr=%0d idx=%h data=%h resp=%0d reads=%0d want 1 3 DEADBEEF 2 0", wc, wi, wd, rc, rd);
    end
    do_req(1'b0, 3'b010, 32'h0C, 32'h0, r0, rc, flt, rd, wc, wi, wd);
    n_tests++;
    if (r0 !== 1'b1 || rc !== 2 || rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL lw ready=%b resp=%0d data=%h want 1 2 DEADBEEF", r0, rc, rdata);
    end
  endtask

  task automatic test_faults;
    logic r0, flt; int rc, rd, wc; logic [31:0] wi, wd;
    logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic        wrs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ads [4] = '{32'h06, 32'h03, 32'h10, 32'h10};
    for (int i = 0; i < 4; i++) begin
      do_req(wrs[i], f3s[i], ads[i], 32'hFFFF_FFFF, r0, rc, flt, rd, wc, wi, wd);
      n_tests++;
      if (rc !== 1 || flt !== 1'b1 || rd !== 0 || wc !== 0) begin
        n_fail++; $display("FAIL fault_%0d resp=%0d fault=%b reads=%0d wr=%0d want 1 1 0 0", i, rc, flt, rd, wc);
      end
    end
    n_tests++;
    if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fault_rdata_hold got %h want DEADBEEF", rdata); end
  endtask

  task automatic test_reset_rmw;
    int writes = 0;
    mem[5] = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b001; addr = 32'h14; wdata = 32'h1234;
    @(posedge clk);
    #1;
    req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    if (mem_write) writes++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rmw_reset_ready got %b want 1", req_ready); end
    n_tests++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL rmw_reset_rdata got %h want 00000000", rdata); end
    if (mem_write) writes++;
    repeat (4) begin
      @(negedge clk);
      if (mem_write) writes++;
    end
    n_tests++;
    if (writes !== 0 || mem[5] !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL rmw_reset_nowrite writes=%0d mem=%h want 0 CAFEF00D", writes, mem[5]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    test_reset;
    test_loads;
    test_sub_store;
    test_word;
    test_faults;
    test_reset_rmw;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-002 SHALL have req_valid input 1: CPU access request.
REQ-003 SHALL have req_ready output 1: unit idle and accepting a request.
REQ-004 SHALL have req_write input 1: 1 = store, 0 = load.
REQ-005 SHALL have funct3 input 3: RV32I width/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-006 SHALL have addr input 32: byte address.
REQ-007 SHALL have wdata input 32: store data, right-aligned.
REQ-008 SHALL have resp_valid output 1: one-cycle completion pulse.
REQ-009 SHALL have rdata output 32: extended load result.
REQ-010 SHALL have fault output 1: qualifies resp_valid; misaligned address or illegal funct3.
REQ-011 SHALL have mem_read output 1: data-memory read enable.
REQ-012 SHALL have mem_write output 1: data-memory write enable, sampled by the memory on the rising clk edge.
REQ-013 SHALL have mem_address output 32: word index = {2'b00, addr[31:2]}.
REQ-014 SHALL have mem_write_data output 32: full word to store.
REQ-015 SHALL have mem_read_data input 32: combinational memory read word, valid in the same cycle as mem_read.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, LOAD, RMW_RD, WRITE and RESP, with all mem_* enables decoded from the state register only.
REQ-017 SHALL assert req_ready only in IDLE, and SHALL accept a request on a clk edge where req_valid and req_ready are both 1.
REQ-018 SHALL latch req_write, funct3, addr and wdata at acceptance, and SHALL ignore later input changes until return to IDLE.
REQ-019 SHALL treat the request as a fault when funct3 is illegal for its direction (loads: 011/110/111; stores: any code other than 000/001/010), when a halfword has addr[0]=1, or when a word has addr[1:0]≠00.
REQ-020 SHALL route requests from IDLE: fault -> RESP; load -> LOAD; sw -> WRITE; sb/sh -> RMW_RD.
REQ-021 SHALL, in LOAD, assert mem_read, extract the byte or halfword selected by addr[1:0], sign- or zero-extend it per funct3, register the result into rdata, then go to RESP.
REQ-022 SHALL, in RMW_RD, assert mem_read, merge wdata[7:0] or wdata[15:0] into mem_read_data at the addressed lane, register the merged word into a store buffer, then go to WRITE.
REQ-023 SHALL, in WRITE, assert mem_write with mem_write_data = store buffer (sw: latched wdata), then go to RESP.
REQ-024 SHALL, in RESP, assert resp_valid for exactly one cycle with fault valid, then return to IDLE.
REQ-025 SHALL meet these latencies with acceptance at edge 0, resp_valid high in cycle N: load N=2, sw N=2, sb/sh N=3, fault N=1.
REQ-026 SHALL perform no memory access (mem_read=mem_write=0) for any faulted request.
REQ-027 SHALL hold rdata until the next non-faulting load completes, and SHALL leave rdata unchanged on stores and faults.
REQ-028 SHALL drive mem_address from the latched addr in every non-IDLE state, and SHALL drive 0 in IDLE.
REQ-029 SHALL accept a new request only in the cycle after RESP (no back-to-back overlap).

Reset
REQ-030 SHALL, on reset=1 at a clk edge, enter IDLE with req_ready=1, resp_valid=0, fault=0, mem_read=0, mem_write=0, rdata=0 and store buffer=0.
REQ-031 SHALL abandon any in-flight operation on reset; a reset asserted in RMW_RD SHALL prevent mem_write in every following cycle.
REQ-032 SHALL have reset take priority over request acceptance on the same edge.

Structure
REQ-033 SHALL place the funct3 width/sign constants and the FSM state encoding in shared package lsu_pkg.
REQ-034 SHALL place lane extraction, sign/zero extension and sub-word merge in one combinational sub-module, lsu_align.
REQ-035 SHALL be 120-400 lines of RTL in total.

Verification
REQ-036 SHALL cover: memory word 0x8000_00F1 at index 4; lb addr 0x10 -> rdata 0xFFFF_FFF1; lbu -> 0x0000_00F1; lh addr 0x12 -> 0xFFFF_8000.
REQ-037 SHALL cover: memory word 0x1122_3344 at index 2; sb addr 0x09 wdata 0xAB -> mem_write in cycle 2 with data 0x1122_AB44; resp_valid in cycle 3.
REQ-038 SHALL cover: sw addr 0x0C wdata 0xDEAD_BEEF -> mem_write cycle 1 at index 3; a subsequent lw addr 0x0C returns 0xDEAD_BEEF at cycle 2.
REQ-039 SHALL cover: lw addr 0x06 and sh addr 0x03 -> resp_valid with fault=1 at cycle 1; no mem_read or mem_write pulse.
REQ-040 SHALL cover: sh accepted, reset asserted during RMW_RD -> no mem_write, req_ready=1 the next cycle, memory unchanged.
